aes_encipher_engine: RTL and testbench
======================================

# aes_encipher_engine

Parametrised AES block-encipher engine covering AES-128, AES-192 and AES-256 per FIPS-197. It runs the initial AddRoundKey, the Nr-1 main rounds and the final round over a single 128-bit state register. SubBytes uses NUM_SBOX_WORDS externally shared S-box words per cycle. It sits between the core's key memory, which supplies round_key combinationally from the round index, and the shared S-box bank, and exposes a next/ready handshake to the core controller.

## Interface
- NUM_SBOX_WORDS, default 1: 32-bit S-box lanes used per SubBytes cycle. Legal values are 1, 2 and 4; other values are illegal.
- clk  in  1  system clock, all registers update on the rising edge.
- reset_n  in  1  reset; one clock, reset is synchronous and active-low.
- next  in  1  start request, sampled only in IDLE.
- keylen  in  2  key length: 0 = 128, 1 = 192, 2 = 256, 3 = reserved (treated as 128). Captured when next is accepted.
- round  out  4  round index requesting a key, equal to the internal round counter.
- round_key  in  128  key for the index on round, valid in the same cycle (combinational lookup).
- sboxw  out  32*NUM_SBOX_WORDS  words to substitute. Lane j is bits [32j+31:32j].
- new_sboxw  in  32*NUM_SBOX_WORDS  substituted words, same lane mapping, valid in the same cycle.
- block  in  128  plaintext, sampled in the INIT cycle.
- new_block  out  128  state register; holds the ciphertext once ready is 1.
- ready  out  1  engine idle, result valid.

## Operation
- State layout: column-major. Word i is bits [127-32i -: 32] and is column i; the MSB byte is row 0.
- Nr depends on the captured keylen: 10, 12 or 14.
- FSM states are IDLE, INIT, SBOX, ROUND.
- IDLE, next=1:
  - capture keylen;
  - round_ctr <= 0, sword_ctr <= 0, ready <= 0;
  - go to INIT.
- IDLE, next=0: stay in IDLE.
- INIT:
  - state <= block ^ round_key, with round = 0;
  - round_ctr <= 1;
  - go to SBOX.
- SBOX:
  - lane j carries state word sword_ctr*NUM_SBOX_WORDS+j;
  - that word is replaced with new_sboxw lane j;
  - sword_ctr advances by 1 per cycle;
  - after 4/NUM_SBOX_WORDS cycles, sword_ctr <= 0 and go to ROUND.
- ROUND, round_ctr < Nr:
  - state <= AddRoundKey(MixColumns(ShiftRows(state)));
  - round_ctr++;
  - go to SBOX.
- ROUND, round_ctr == Nr:
  - state <= AddRoundKey(ShiftRows(state)), with no MixColumns;
  - ready <= 1;
  - go to IDLE.
- ShiftRows rotates row r left by r bytes.
- MixColumns is the standard matrix {2,3,1,1} circulant over GF(2^8), with xtime polynomial 0x1b.
- sboxw is 0 outside SBOX.
- new_block is valid only while ready=1. During operation it shows intermediate state and must not be consumed.
- next while busy is ignored; it is not queued.
- next held high: a new operation starts in the IDLE cycle immediately following ready rising.
- keylen and block changes while busy have no effect. block is used only in the INIT cycle.

## Timing
- Reset values: ready=1, new_block=0, sboxw=0, round=0; FSM in IDLE; both counters 0.
- Reset mid-operation aborts the operation and restores all reset values at the next edge.
- Latency: ready rises L = 1 + Nr*(4/NUM_SBOX_WORDS + 1) edges after the edge that samples next.
  - NUM_SBOX_WORDS=1: 51 / 61 / 71 for 128 / 192 / 256.
  - NUM_SBOX_WORDS=2: 31 / 37 / 43.
  - NUM_SBOX_WORDS=4: 21 / 25 / 29.
- ready falls on the edge after next is sampled in IDLE.
- round is stable for the whole SBOX+ROUND span of a round. It reads 0 in INIT and in IDLE after reset; after completion it holds Nr until the next start.
- S-box and key paths are combinational in the same cycle. No response cycle is inserted.

## Test plan
- AES-128, NUM_SBOX_WORDS=1, FIPS-197 C.1: key 000102…0f, plaintext 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises exactly 51 edges after next is sampled.
- AES-192 and AES-256 with the C.2/C.3 keys and the same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089, at 61 and 71 edges respectively. Repeat the C.1, C.2 and C.3 vectors with NUM_SBOX_WORDS=2 and 4; expect identical results at the latencies listed under Timing.
- Pulse next at cycles 5, 20 and 40 of a run, and change keylen mid-run -> ciphertext and latency unchanged; exactly one ready rise.
- Assert reset_n=0 at cycle 15 of an AES-256 run -> the next edge gives ready=1, new_block=0, round=0, sboxw=0. A fresh C.1 run then passes.
- Hold next=1 with back-to-back C.1/C.3 vectors (block changed in the ready cycle) -> both ciphertexts correct; the second start occurs the cycle after the first ready; keylen=3 produces the C.1 result.

Source files
------------

// File: rtl/aes_encipher_engine.sv
// Iterative AES-128/192/256 block encipher datapath over one 128-bit state register.
// SubBytes goes through an external shared S-box bank, NUM_SBOX_WORDS words per cycle.
module aes_encipher_engine #(
    parameter int unsigned NUM_SBOX_WORDS = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          next,
    input  logic [1:0]                    keylen,
    output logic [3:0]                    round,
    input  logic [127:0]                  round_key,
    output logic [32*NUM_SBOX_WORDS-1:0]  sboxw,
    input  logic [32*NUM_SBOX_WORDS-1:0]  new_sboxw,
    input  logic [127:0]                  block,
    output logic [127:0]                  new_block,
    output logic                          ready
);

    localparam int unsigned SboxCycles = 4 / NUM_SBOX_WORDS;
    localparam logic [1:0]  SwordLast  = 2'(SboxCycles - 1);

    if (!(NUM_SBOX_WORDS == 1 || NUM_SBOX_WORDS == 2 || NUM_SBOX_WORDS == 4)) begin : g_bad_param
        $error("NUM_SBOX_WORDS must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StSbox,
        StRound
    } fsm_e;

    fsm_e                          r_fsm;
    fsm_e                          w_fsm_d;
    logic [127:0]                  r_state;
    logic [127:0]                  w_state_d;
    logic [3:0]                    r_round_ctr;
    logic [3:0]                    w_round_ctr_d;
    logic [1:0]                    r_sword_ctr;
    logic [1:0]                    w_sword_ctr_d;
    logic [1:0]                    r_keylen;
    logic [1:0]                    w_keylen_d;
    logic                          r_ready;
    logic                          w_ready_d;

    logic [3:0]                    w_nr;
    logic [31:0]                   w_col [4];
    logic [31:0]                   w_sub_col [4];
    logic [1:0]                    w_lane_idx [NUM_SBOX_WORDS];
    logic [32*NUM_SBOX_WORDS-1:0]  w_lanes;
    logic [32*NUM_SBOX_WORDS-1:0]  w_sboxw;
    logic [127:0]                  w_sub_state;
    logic [127:0]                  w_shifted;
    logic [127:0]                  w_mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (row r, col c) sits at bits [127-32c-8r -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    always_comb begin
        unique case (r_keylen)
            2'd1:    w_nr = 4'd12;
            2'd2:    w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end

    // Lane j serves state word sword_ctr*NUM_SBOX_WORDS+j this cycle.
    always_comb begin
        w_lanes = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            w_col[c]     = r_state[127 - 32*c -: 32];
            w_sub_col[c] = r_state[127 - 32*c -: 32];
        end
        for (int unsigned j = 0; j < NUM_SBOX_WORDS; j++) begin
            w_lane_idx[j]            = 2'(32'(r_sword_ctr) * NUM_SBOX_WORDS + j);
            w_lanes[32*j +: 32]      = w_col[w_lane_idx[j]];
            w_sub_col[w_lane_idx[j]] = new_sboxw[32*j +: 32];
        end
        w_sub_state = {w_sub_col[0], w_sub_col[1], w_sub_col[2], w_sub_col[3]};
    end

    always_comb begin
        w_shifted = shift_rows(r_state);
        w_mixed   = {mix_column(w_shifted[127:96]), mix_column(w_shifted[95:64]),
                     mix_column(w_shifted[63:32]),  mix_column(w_shifted[31:0])};
    end

    always_comb begin
        w_fsm_d       = r_fsm;
        w_state_d     = r_state;
        w_round_ctr_d = r_round_ctr;
        w_sword_ctr_d = r_sword_ctr;
        w_keylen_d    = r_keylen;
        w_ready_d     = r_ready;
        w_sboxw       = '0;

        unique case (r_fsm)
            StIdle: begin
                if (next) begin
                    w_keylen_d    = keylen;
                    w_round_ctr_d = 4'd0;
                    w_sword_ctr_d = 2'd0;
                    w_ready_d     = 1'b0;
                    w_fsm_d       = StInit;
                end
            end
            StInit: begin
                w_state_d     = block ^ round_key;
                w_round_ctr_d = 4'd1;
                w_fsm_d       = StSbox;
            end
            StSbox: begin
                w_sboxw   = w_lanes;
                w_state_d = w_sub_state;
                if (r_sword_ctr == SwordLast) begin
                    w_sword_ctr_d = 2'd0;
                    w_fsm_d       = StRound;
                end else begin
                    w_sword_ctr_d = r_sword_ctr + 2'd1;
                end
            end
            StRound: begin
                if (r_round_ctr == w_nr) begin
                    // Final round drops MixColumns; round_ctr is left at Nr.
                    w_state_d = w_shifted ^ round_key;
                    w_ready_d = 1'b1;
                    w_fsm_d   = StIdle;
                end else begin
                    w_state_d     = w_mixed ^ round_key;
                    w_round_ctr_d = r_round_ctr + 4'd1;
                    w_fsm_d       = StSbox;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm       <= StIdle;
            r_state     <= '0;
            r_round_ctr <= 4'd0;
            r_sword_ctr <= 2'd0;
            r_keylen    <= 2'd0;
            r_ready     <= 1'b1;
        end else begin
            r_fsm       <= w_fsm_d;
            r_state     <= w_state_d;
            r_round_ctr <= w_round_ctr_d;
            r_sword_ctr <= w_sword_ctr_d;
            r_keylen    <= w_keylen_d;
            r_ready     <= w_ready_d;
        end
    end

    assign round     = r_round_ctr;
    assign sboxw     = w_sboxw;
    assign new_block = r_state;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_engine.sv
// Directed FIPS-197 vectors against three engine instances (1, 2 and 4 S-box lanes).
// The bench plays key memory (FIPS key expansion) and the shared S-box bank.
module tb_aes_encipher_engine;

    localparam logic [127:0] Pt = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic              clk;
    logic              reset_n;
    logic [2:0]        next_v;
    logic [2:0][1:0]   keylen_v;
    logic [2:0][127:0] block_v;
    logic [2:0][3:0]   round_v;
    logic [2:0][127:0] rkey_v;
    logic [2:0][127:0] nblk_v;
    logic [2:0]        ready_v;
    logic [31:0]       sw0, nsw0;
    logic [63:0]       sw1, nsw1;
    logic [127:0]      sw2, nsw2;
    logic [127:0]      rk_tab [3][15];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: x^254 inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign nsw0 = sub_word(sw0);
    assign nsw1 = {sub_word(sw1[63:32]), sub_word(sw1[31:0])};
    assign nsw2 = {sub_word(sw2[127:96]), sub_word(sw2[95:64]),
                   sub_word(sw2[63:32]), sub_word(sw2[31:0])};

    assign rkey_v[0] = rk_tab[0][round_v[0]];
    assign rkey_v[1] = rk_tab[1][round_v[1]];
    assign rkey_v[2] = rk_tab[2][round_v[2]];

    aes_encipher_engine #(.NUM_SBOX_WORDS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .next(next_v[0]), .keylen(keylen_v[0]),
        .round(round_v[0]), .round_key(rkey_v[0]), .sboxw(sw0), .new_sboxw(nsw0),
        .block(block_v[0]), .new_block(nblk_v[0]), .ready(ready_v[0])
    );
    aes_encipher_engine #(.NUM_SBOX_WORDS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .next(next_v[1]), .keylen(keylen_v[1]),
        .round(round_v[1]), .round_key(rkey_v[1]), .sboxw(sw1), .new_sboxw(nsw1),
        .block(block_v[1]), .new_block(nblk_v[1]), .ready(ready_v[1])
    );
    aes_encipher_engine #(.NUM_SBOX_WORDS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .next(next_v[2]), .keylen(keylen_v[2]),
        .round(round_v[2]), .round_key(rkey_v[2]), .sboxw(sw2), .new_sboxw(nsw2),
        .block(block_v[2]), .new_block(nblk_v[2]), .ready(ready_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    endfunction

    function automatic int lat_of(input int d, input logic [1:0] kl);
        int lanes;
        lanes = (d == 0) ? 1 : (d == 1) ? 2 : 4;
        return 1 + nr_of(kl) * (4 / lanes + 1);
    endfunction

    function automatic logic [127:0] ct_of(input logic [1:0] kl);
        return (kl == 2'd1) ? Ct192 : (kl == 2'd2) ? Ct256 : Ct128;
    endfunction

    function automatic logic [127:0] sboxw_of(input int d);
        if (d == 0) return {96'h0, sw0};
        if (d == 1) return {64'h0, sw1};
        return sw2;
    endfunction

    // FIPS-197 key expansion of the test key 00 01 02 ... for the given length.
    task automatic load_keys(input int d, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) begin
            w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        end
        rcon = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = t ^ w[i-nk];
        end
        for (int r = 0; r < 15; r++) begin
            if (r <= nr) rk_tab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tab[d][r] = '0;
        end
    endtask

    // Returns at #1 after the edge that samples next; checks ready fell there.
    task automatic start_op(input int d, input logic [1:0] kl);
        @(negedge clk);
        load_keys(d, kl);
        keylen_v[d] = kl;
        block_v[d]  = Pt;
        next_v[d]   = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("d%0d_kl%0d_ready_fall", d, kl), 128'(ready_v[d]), 128'd0);
        next_v[d] = 1'b0;
    endtask

    // Counts edges to the ready rise; block and keylen are disturbed once busy.
    task automatic wait_ready(input int d, input int exp_lat, input bit pulse, input string tag);
        int lat;
        lat = 0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                block_v[d]  = ~block_v[d];
                keylen_v[d] = keylen_v[d] ^ 2'b10;
            end
            if (pulse) begin
                if (n == 5 || n == 20 || n == 40)      next_v[d] = 1'b1;
                else if (n == 6 || n == 21 || n == 41) next_v[d] = 1'b0;
            end
            if (ready_v[d]) lat = n;
        end
        check($sformatf("%s_latency", tag), 128'(lat), 128'(exp_lat));
    endtask

    task automatic run_op(input int d, input logic [1:0] kl, input bit pulse);
        string tag;
        tag = $sformatf("d%0d_kl%0d%s", d, kl, pulse ? "_pulse" : "");
        start_op(d, kl);
        wait_ready(d, lat_of(d, kl), pulse, tag);
        check($sformatf("%s_ct", tag), nblk_v[d], ct_of(kl));
        check($sformatf("%s_round", tag), 128'(round_v[d]), 128'(nr_of(kl)));
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("%s_hold", tag), {127'd0, ready_v[d]} | {nblk_v[d] ^ ct_of(kl)},
              128'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        next_v   = '0;
        keylen_v = '0;
        block_v  = '0;
        for (int d = 0; d < 3; d++) load_keys(d, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_rst_ready", d), 128'(ready_v[d]), 128'd1);
            check($sformatf("d%0d_rst_block", d), nblk_v[d], 128'd0);
            check($sformatf("d%0d_rst_round", d), 128'(round_v[d]), 128'd0);
            check($sformatf("d%0d_rst_sboxw", d), sboxw_of(d), 128'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 3; k++) run_op(d, 2'(k), 1'b0);
        end

        run_op(0, 2'd0, 1'b1);

        // Abort an AES-256 run while it is mid-SubBytes in round 3.
        start_op(0, 2'd2);
        repeat (14) @(posedge clk);
        #1;
        check("abort_mid_round", 128'(round_v[0]), 128'd3);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", 128'(ready_v[0]), 128'd1);
        check("abort_block", nblk_v[0], 128'd0);
        check("abort_round", 128'(round_v[0]), 128'd0);
        check("abort_sboxw", sboxw_of(0), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(0, 2'd0, 1'b0);

        // next held high: C.1, then C.3, then reserved keylen 3 behaving as C.1.
        @(negedge clk);
        load_keys(0, 2'd0);
        keylen_v[0] = 2'd0;
        block_v[0]  = Pt;
        next_v[0]   = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_a_fall", 128'(ready_v[0]), 128'd0);
        wait_ready(0, 51, 1'b0, "b2b_a");
        check("b2b_a_ct", nblk_v[0], Ct128);
        load_keys(0, 2'd2);
        keylen_v[0] = 2'd2;
        block_v[0]  = Pt;
        @(posedge clk);
        #1;
        check("b2b_b_restart", 128'(ready_v[0]), 128'd0);
        check("b2b_b_round0", 128'(round_v[0]), 128'd0);
        wait_ready(0, 71, 1'b0, "b2b_b");
        check("b2b_b_ct", nblk_v[0], Ct256);
        load_keys(0, 2'd3);
        keylen_v[0] = 2'd3;
        block_v[0]  = Pt;
        @(posedge clk);
        #1;
        check("b2b_c_restart", 128'(ready_v[0]), 128'd0);
        next_v[0] = 1'b0;
        wait_ready(0, 51, 1'b0, "b2b_c");
        check("b2b_c_ct", nblk_v[0], Ct128);
        check("b2b_c_round", 128'(round_v[0]), 128'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
